// File: rtl/chess_pkg.sv
// Shared seven-segment constants and digit positions for the chess timer displays.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package chess_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit index 0 is the rightmost display position.
    localparam logic [2:0] DIG_S2U = 3'd0;
    localparam logic [2:0] DIG_S2T = 3'd1;
    localparam logic [2:0] DIG_M2U = 3'd2;
    localparam logic [2:0] DIG_M2T = 3'd3;
    localparam logic [2:0] DIG_S1U = 3'd4;
    localparam logic [2:0] DIG_S1T = 3'd5;
    localparam logic [2:0] DIG_M1U = 3'd6;
    localparam logic [2:0] DIG_M1T = 3'd7;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_BLANK   = 1'b1
    } blink_phase_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Combinational split of a 0..59 binary value into BCD tens and units.
// Values 60..63 report valid=0 with zeroed digits.
module bin6_to_bcd (
    input  logic [5:0] value,
    output logic       valid,
    output logic [3:0] tens,
    output logic [3:0] units
);

    always_comb begin
        valid = 1'b1;
        tens  = 4'd0;
        units = 4'(value);
        if (value > 6'd59) begin
            valid = 1'b0;
            units = 4'd0;
        end else if (value >= 6'd50) begin
            tens  = 4'd5;
            units = 4'(value - 6'd50);
        end else if (value >= 6'd40) begin
            tens  = 4'd4;
            units = 4'(value - 6'd40);
        end else if (value >= 6'd30) begin
            tens  = 4'd3;
            units = 4'(value - 6'd30);
        end else if (value >= 6'd20) begin
            tens  = 4'd2;
            units = 4'(value - 6'd20);
        end else if (value >= 6'd10) begin
            tens  = 4'd1;
            units = 4'(value - 6'd10);
        end
    end

endmodule

// File: rtl/chess_display_scan.sv
// Eight-digit multiplexed display of both players' clocks with turn marker
// and flag-fall blinking; values are frozen per frame to avoid tearing.
module chess_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       player1,
    input  logic       player2,
    input  logic [5:0] min1,
    input  logic [5:0] sec1,
    input  logic [5:0] min2,
    input  logic [5:0] sec2,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    import chess_pkg::*;

    localparam int REFRESH_W = $clog2(REFRESH_DIV);
    localparam int BLINK_W   = $clog2(BLINK_DIV);

    logic [REFRESH_W-1:0] refresh_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [2:0]           digit_idx;
    blink_phase_t         blink_phase;
    logic                 first_pending;

    logic [5:0] snap_min1, snap_sec1, snap_min2, snap_sec2;
    logic       snap_p1, snap_p2;

    logic [5:0] view_min1, view_sec1, view_min2, view_sec2;
    logic       view_p1, view_p2;

    logic refresh_tc, blink_tc, capture;

    logic       m1_valid, s1_valid, m2_valid, s2_valid;
    logic [3:0] m1_tens, m1_units, s1_tens, s1_units;
    logic [3:0] m2_tens, m2_units, s2_tens, s2_units;

    logic       digit_valid, digit_p1, dp_on, flag1, flag2, blank_digit;
    logic [3:0] digit_val;
    logic [6:0] seg_next;
    logic       dp_next;

    assign refresh_tc = (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1));
    assign blink_tc   = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign capture    = enable && (first_pending || (refresh_tc && digit_idx == DIG_M1T));

    // Right after reset the snapshot is still empty, so show live inputs that cycle.
    assign view_min1 = first_pending ? min1    : snap_min1;
    assign view_sec1 = first_pending ? sec1    : snap_sec1;
    assign view_min2 = first_pending ? min2    : snap_min2;
    assign view_sec2 = first_pending ? sec2    : snap_sec2;
    assign view_p1   = first_pending ? player1 : snap_p1;
    assign view_p2   = first_pending ? player2 : snap_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= DIG_S2U;
            blink_cnt   <= '0;
            blink_phase <= PHASE_VISIBLE;
        end else if (enable) begin
            if (refresh_tc) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 3'd1;
            end else begin
                refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            end
            if (blink_tc) begin
                blink_cnt   <= '0;
                blink_phase <= (blink_phase == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_min1     <= '0;
            snap_sec1     <= '0;
            snap_min2     <= '0;
            snap_sec2     <= '0;
            snap_p1       <= 1'b0;
            snap_p2       <= 1'b0;
            first_pending <= 1'b1;
        end else if (capture) begin
            snap_min1     <= min1;
            snap_sec1     <= sec1;
            snap_min2     <= min2;
            snap_sec2     <= sec2;
            snap_p1       <= player1;
            snap_p2       <= player2;
            first_pending <= 1'b0;
        end
    end

    bin6_to_bcd u_conv_m1 (.value(view_min1), .valid(m1_valid), .tens(m1_tens), .units(m1_units));
    bin6_to_bcd u_conv_s1 (.value(view_sec1), .valid(s1_valid), .tens(s1_tens), .units(s1_units));
    bin6_to_bcd u_conv_m2 (.value(view_min2), .valid(m2_valid), .tens(m2_tens), .units(m2_units));
    bin6_to_bcd u_conv_s2 (.value(view_sec2), .valid(s2_valid), .tens(s2_tens), .units(s2_units));

    assign flag1 = (view_min1 == 6'd0) && (view_sec1 == 6'd0);
    assign flag2 = (view_min2 == 6'd0) && (view_sec2 == 6'd0);

    always_comb begin
        digit_valid = 1'b1;
        digit_val   = 4'd0;
        digit_p1    = 1'b0;
        dp_on       = 1'b0;
        case (digit_idx)
            DIG_S2U: begin digit_valid = s2_valid; digit_val = s2_units; end
            DIG_S2T: begin digit_valid = s2_valid; digit_val = s2_tens;  end
            DIG_M2U: begin digit_valid = m2_valid; digit_val = m2_units; end
            DIG_M2T: begin digit_valid = m2_valid; digit_val = m2_tens;  dp_on = view_p2; end
            DIG_S1U: begin digit_valid = s1_valid; digit_val = s1_units; digit_p1 = 1'b1; end
            DIG_S1T: begin digit_valid = s1_valid; digit_val = s1_tens;  digit_p1 = 1'b1; end
            DIG_M1U: begin digit_valid = m1_valid; digit_val = m1_units; digit_p1 = 1'b1; end
            DIG_M1T: begin digit_valid = m1_valid; digit_val = m1_tens;  digit_p1 = 1'b1; dp_on = view_p1; end
            default: begin digit_valid = 1'b0; end
        endcase

        blank_digit = (blink_phase == PHASE_BLANK) && (digit_p1 ? flag1 : flag2);
        if (blank_digit) begin
            seg_next = SEG_BLANK;
        end else if (!digit_valid) begin
            seg_next = SEG_DASH;
        end else begin
            seg_next = seg_encode(digit_val);
        end
        dp_next = !(dp_on && !blank_digit);
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << digit_idx);
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_chess_display_scan.sv
// Directed self-checking bench for chess_display_scan with short refresh and blink periods.
// Each frame is 32 enabled cycles (8 digits x 4), matching one blink half-period.
module tb_chess_display_scan;

    localparam int REF = 4;
    localparam int BLK = 32;

    logic       clk = 1'b0;
    logic       reset, enable, player1, player2;
    logic [5:0] min1, sec1, min2, sec2;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int n = 0;
    int checks = 0;
    int failures = 0;

    chess_display_scan #(.REFRESH_DIV(REF), .BLINK_DIV(BLK)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .player1(player1), .player2(player2),
        .min1(min1), .sec1(sec1), .min2(min2), .sec2(sec2),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s (n=%0d): got %h, expected %h", tag, n, observed, expected);
        end
    endtask

    // n counts enabled, non-reset edges; the digit shown after edge n is ((n-1)/REF)%8.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (enable && !reset) n++;
    endtask

    task automatic checkBlank(input string tag);
        checkOutput({tag, "_an"}, an, 8'hFF);
        checkOutput({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        checkOutput({tag, "_dp"}, {7'b0, dp}, 8'h01);
    endtask

    task automatic applyStimulus(input logic [7:0][6:0] segs, input logic [7:0] dp_mask, input int cycles);
        int idx;
        for (int c = 0; c < cycles; c++) begin
            stepCycle();
            idx = ((n - 1) / REF) % 8;
            checkOutput("an", an, ~(8'b1 << idx));
            checkOutput("seg", {1'b0, seg}, {1'b0, segs[idx]});
            checkOutput("dp", {7'b0, dp}, {7'b0, ~dp_mask[idx]});
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        player1 = 1'b1; player2 = 1'b0;
        min1 = 6'd5; sec1 = 6'd39; min2 = 6'd12; sec2 = 6'd7;

        repeat (3) begin
            stepCycle();
            checkBlank("reset");
        end
        reset = 1'b0;

        // Frame 0: first digit uses live inputs, then the snapshot.
        applyStimulus({7'h40, 7'h12, 7'h30, 7'h10, 7'h79, 7'h24, 7'h40, 7'h78}, 8'h80, 32);

        // Frame 1: inputs change at idx2 but the frame keeps its snapshot.
        applyStimulus({7'h40, 7'h12, 7'h30, 7'h10, 7'h79, 7'h24, 7'h40, 7'h78}, 8'h80, 9);
        sec2 = 6'd8; min1 = 6'd9;
        applyStimulus({7'h40, 7'h12, 7'h30, 7'h10, 7'h79, 7'h24, 7'h40, 7'h78}, 8'h80, 23);

        // Frame 2: new values visible; player 2 flag falls and takes the turn.
        applyStimulus({7'h40, 7'h10, 7'h30, 7'h10, 7'h79, 7'h24, 7'h40, 7'h00}, 8'h80, 1);
        min2 = 6'd0; sec2 = 6'd0; player1 = 1'b0; player2 = 1'b1;
        applyStimulus({7'h40, 7'h10, 7'h30, 7'h10, 7'h79, 7'h24, 7'h40, 7'h00}, 8'h80, 31);

        // Frame 3 blank phase, frame 4 visible phase for the flagged player.
        applyStimulus({7'h40, 7'h10, 7'h30, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 8'h00, 32);
        applyStimulus({7'h40, 7'h10, 7'h30, 7'h10, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h08, 1);
        sec1 = 6'd62;
        applyStimulus({7'h40, 7'h10, 7'h30, 7'h10, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h08, 31);

        // Frame 5: out-of-range seconds show dashes.
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 8'h00, 32);

        // Frame 6: disable on the first cycle of idx5, then resume with the dwell intact.
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h08, 21);
        enable = 1'b0;
        repeat (10) begin
            stepCycle();
            checkBlank("disabled");
        end
        enable = 1'b1;
        player1 = 1'b1;
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h08, 11);

        // Frame 7 blank phase hides player 2's point; frame 8 shows both points.
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 8'h80, 1);
        sec2 = 6'd5;
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 8'h80, 31);
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h12}, 8'h88, 39);

        // Reset mid-frame, then restart from idx0.
        reset = 1'b1;
        stepCycle();
        checkBlank("midreset");
        reset = 1'b0;
        n = 0;
        applyStimulus({7'h40, 7'h10, 7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h12}, 8'h88, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_display_scan.md
Name: chess_display_scan

Overview:
Reader side of the chess-timer countdown outputs. It takes both players' minutes and seconds (binary, 0..59) and converts each to two BCD digits. It then time-multiplexes the eight digits onto the Nexys 4 seven-segment display. It also marks the active player with a decimal point and blinks a player's digits once that player's time reaches 00:00 (flag fall).

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is driven (1 kHz per digit at 100 MHz); minimum 2.
BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz blink at 100 MHz); minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  display on; low blanks all digits
player1  in  1  player 1 running (turn indicator)
player2  in  1  player 2 running
min1  in  6  player 1 minutes, binary
sec1  in  6  player 1 seconds, binary
min2  in  6  player 2 minutes, binary
sec2  in  6  player 2 seconds, binary
an  out  8  digit anodes, active-low, an[0] = rightmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low

Behaviour:
- Reset (sync, active-high, overrides everything): an=8'hFF, seg=7'h7F, dp=1; refresh counter=0, digit index=0, blink counter=0, blink phase=visible, snapshot registers=0.
- Refresh counter counts 0..REFRESH_DIV-1. On its terminal count the digit index advances (0..7, then wraps to 0).
- Digit map:
  - idx0 = sec2 units, idx1 = sec2 tens, idx2 = min2 units, idx3 = min2 tens.
  - idx4 = sec1 units, idx5 = sec1 tens, idx6 = min1 units, idx7 = min1 tens.
- Snapshot: all four inputs and player1/player2 are captured into snapshot registers on the cycle the index wraps 7->0, and on the first cycle after reset. A frame therefore never mixes old and new values (no tearing).
- Conversion: tens = v/10, units = v%10 for v in 0..59. A value of 60..63 shows dash (7'h3F) on both of its digits.
- Segment codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Blank = 7F.
- Outputs are registered: an/seg/dp reflect the digit index one clk after the index changes. Exactly one an bit is low at a time when enabled.
- dp is low on idx7 when snapshot player1=1 and on idx3 when snapshot player2=1. Both may be lit. dp is high elsewhere.
- Blink:
  - The blink counter runs continuously and toggles the blink phase every BLINK_DIV cycles.
  - A player whose snapshot min=0 and sec=0 has its four digits driven seg=7F and dp=1 during the blank phase. Its an bit still cycles.
  - The other player is unaffected.
- enable=0: an=FF, seg=7F, dp=1 on the next clk. Refresh, blink and snapshot logic freeze. Re-enable resumes from the frozen index.
- Reset mid-frame returns to idx0 with blank outputs on the same edge. The first enabled digit drive appears one cycle after reset deasserts.
- Input changes within a frame have no effect until the next 7->0 wrap.

Decomposition:
- Shared package chess_pkg: the seven-segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the digit-index localparams (DIG_S2U .. DIG_M1T). The same constants serve later display blocks.
- One sub-module, bin6_to_bcd: combinational conversion of a 6-bit value to {valid, tens[3:0], units[3:0]}, with valid=0 for values above 59.
- Scan counters, snapshot registers, blink logic and the output registers stay in the top module.

Test Plan:
All scenarios use REFRESH_DIV=4 and BLINK_DIV=32.
1. Reset held for 3 cycles, then released with enable=1 -> during reset an=FF, seg=7F, dp=1. One cycle after release, an=FE, with seg showing sec2 units.
2. min1=5, sec1=39, min2=12, sec2=7, player1=1, player2=0, full frame captured:
   - idx0..3 -> seg 78, 40, 24, 79.
   - idx4..7 -> seg 10, 30, 12, 40.
   - dp=0 only while an=7F.
3. Change sec2 from 7 to 8 while at idx2 -> idx0 of the next frame still shows 78 until after the 7->0 wrap. The frame after that shows 00.
4. min2=0, sec2=0, player1 values nonzero -> over 64 cycles, digits idx0..3 alternate between 40 and 7F every 32 cycles. Digits idx4..7 are steady.
5. sec1=62 -> idx4 and idx5 both show 3F; min1 digits remain correct.
6. Drop enable at idx5 for 10 cycles -> an=FF, seg=7F one cycle later. On re-enable, an=DF, with idx5 still selected and its remaining dwell intact.
